// File: rtl/prio_key_encoder.sv
`default_nettype none
// ============================================================================
// Module   : prio_key_encoder
// Brief    : Debounced priority encoder for active-low key lines with a
//            valid/ready handshake and a saturating accepted-press counter.
// Revision : 1.0 - initial release
// ============================================================================
module prio_key_encoder #(
    parameter int N_IN           = 9,
    parameter int DEB_CYCLES     = 4,
    parameter int ACTIVE_LOW_OUT = 1,
    localparam int CW            = $clog2(N_IN + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] a_n,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [CW-1:0]   code_o,
    output logic            busy_o,
    output logic [7:0]      press_cnt_o
);

    generate
        if (N_IN < 2 || N_IN > 15 || DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_param_check
            $error("prio_key_encoder: N_IN must be 2..15 and DEB_CYCLES 1..255");
        end
    endgenerate

    localparam logic [7:0]    c_deb_last  = 8'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] c_idle_code = (ACTIVE_LOW_OUT != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESENT  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [N_IN-1:0] r_sync1, r_sync2;
    logic [CW-1:0]   w_enc;
    logic [CW-1:0]   r_cand, w_cand_nxt;
    logic [CW-1:0]   r_code, w_code_nxt;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic [7:0]      r_press, w_press_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_busy;

    function automatic logic [CW-1:0] fmt_code(input logic [CW-1:0] v);
        return (ACTIVE_LOW_OUT != 0) ? ~v : v;
    endfunction

    // Higher indices overwrite lower ones, so the highest low line wins.
    always_comb begin
        w_enc = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!r_sync2[i]) begin
                w_enc = CW'(i + 1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_code_nxt  = r_code;
        w_press_nxt = r_press;
        case (r_state)
            ST_IDLE: begin
                if (w_enc != '0) begin
                    w_cand_nxt  = w_enc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (w_enc == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_enc != r_cand) begin
                    w_cand_nxt = w_enc;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = ST_PRESENT;
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = fmt_code(r_cand);
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_PRESENT: begin
                // Key lines are deliberately not looked at while the code waits.
                if (ready_i) begin
                    w_valid_nxt = 1'b0;
                    w_code_nxt  = c_idle_code;
                    w_press_nxt = (r_press == 8'hFF) ? r_press : r_press + 8'd1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_enc != '0) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_code  <= c_idle_code;
            r_press <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= a_n;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_code  <= w_code_nxt;
            r_press <= w_press_nxt;
            // Registered copy of the next-state decode keeps busy_o flop-driven.
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign valid_o     = r_valid;
    assign code_o      = r_code;
    assign busy_o      = r_busy;
    assign press_cnt_o = r_press;

endmodule
`default_nettype wire

// File: tb/tb_prio_key_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_key_encoder
// Brief    : Self-checking bench for prio_key_encoder with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_key_encoder;

    localparam int N_IN = 9;
    localparam int DEB  = 4;
    localparam int CW   = 4;

    localparam int M_LOOK  = 0;
    localparam int M_HOLD  = 1;
    localparam int M_QUIET = 2;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic            ready_i = 1'b0;
    logic [N_IN-1:0] a_n     = '0;
    logic            valid_o;
    logic [CW-1:0]   code_o;
    logic            busy_o;
    logic [7:0]      press_cnt_o;

    prio_key_encoder #(
        .N_IN           (N_IN),
        .DEB_CYCLES     (DEB),
        .ACTIVE_LOW_OUT (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_n         (a_n),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .code_o      (code_o),
        .busy_o      (busy_o),
        .press_cnt_o (press_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cycles = 0;
    logic [3:0] pulse_code = 4'hF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: run lengths of identical samples decide everything.
    int         m_mode  = M_LOOK;
    int         m_run   = 0;
    int         m_quiet = 0;
    int         m_cand  = 0;
    int         m_press = 0;
    int         m_e     = 0;
    logic       m_valid = 1'b0;
    logic [8:0] m_s1    = '1;
    logic [8:0] m_s2    = '1;

    function automatic int top_key(input logic [8:0] a);
        for (int i = 8; i >= 0; i--) begin
            if (a[i] == 1'b0) return i + 1;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_LOOK; m_run = 0; m_quiet = 0; m_cand = 0;
            m_press = 0; m_valid = 1'b0; m_s1 = '1; m_s2 = '1;
        end else begin
            m_e  = top_key(m_s2);
            m_s2 = m_s1;
            m_s1 = a_n;
            case (m_mode)
                M_LOOK: begin
                    if (m_e == 0) m_run = 0;
                    else if (m_run > 0 && m_e == m_cand) m_run++;
                    else begin m_run = 1; m_cand = m_e; end
                    if (m_run == DEB + 1) begin m_mode = M_HOLD; m_valid = 1'b1; end
                end
                M_HOLD: begin
                    if (ready_i) begin
                        m_valid = 1'b0;
                        if (m_press < 255) m_press++;
                        m_mode = M_QUIET; m_quiet = 0;
                    end
                end
                default: begin
                    if (m_e == 0) m_quiet++; else m_quiet = 0;
                    if (m_quiet == DEB) begin m_mode = M_LOOK; m_run = 0; end
                end
            endcase
        end
    end

    function automatic logic [3:0] exp_code();
        logic [3:0] v;
        v = 4'(m_cand);
        return m_valid ? ~v : 4'hF;
    endfunction

    task automatic cmp_all(input string tag);
        check({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
        check({tag, ".code"},  32'(code_o),  32'(exp_code()));
        check({tag, ".busy"},  32'(busy_o),  32'((m_mode != M_LOOK) || (m_run > 0)));
        check({tag, ".press"}, 32'(press_cnt_o), 32'(m_press));
    endtask

    task automatic step();
        @(negedge clk);
        cmp_all("cyc");
        if (valid_o) begin
            pulse_cycles++;
            pulse_code = code_o;
        end
    endtask

    task automatic wait_valid(input int maxc, output int k, output logic [3:0] code);
        k = 0;
        code = 4'hF;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (valid_o) begin
                k = i;
                code = code_o;
                break;
            end
        end
    endtask

    int         k;
    logic [3:0] c;

    initial begin
        // Reset with every line low: outputs must show reset values.
        repeat (3) @(negedge clk);
        check("rst.code",  32'(code_o), 32'hF);
        check("rst.valid", 32'(valid_o), 32'h0);
        check("rst.busy",  32'(busy_o), 32'h0);
        check("rst.press", 32'(press_cnt_o), 32'h0);
        a_n = '1;
        rst_n = 1'b1;
        repeat (4) step();

        // Single key 8 with ready high: one pulse, latency 7 edges.
        ready_i = 1'b1;
        a_n = ~9'h100;
        pulse_cycles = 0;
        wait_valid(20, k, c);
        check("single.latency", 32'(k), 32'd7);
        check("single.code", 32'(c), 32'h6);
        repeat (18) step();
        check("single.pulses", 32'(pulse_cycles), 32'd1);
        check("single.press", 32'(press_cnt_o), 32'd1);
        a_n = '1;
        repeat (8) step();

        // Priority: lines 2 and 6 low together.
        a_n = 9'h1BB;
        wait_valid(20, k, c);
        check("prio.seen", 32'(k != 0), 32'd1);
        check("prio.code", 32'(c), 32'h8);
        a_n = '1;
        repeat (8) step();

        // Bounce on line 3 for 20 cycles, then held.
        pulse_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            a_n = (i % 2 == 0) ? ~9'h008 : 9'h1FF;
            repeat (2) step();
        end
        a_n = ~9'h008;
        repeat (15) step();
        check("bounce.pulses", 32'(pulse_cycles), 32'd1);
        check("bounce.code", 32'(pulse_code), 32'hB);
        a_n = '1;
        repeat (8) step();

        // Backpressure: code held while ready low, line switch ignored.
        ready_i = 1'b0;
        a_n = ~9'h020;
        wait_valid(20, k, c);
        check("bp.code", 32'(c), 32'h9);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) a_n = ~9'h002;
            step();
            check("bp.hold.valid", 32'(valid_o), 32'd1);
            check("bp.hold.code", 32'(code_o), 32'h9);
        end
        ready_i = 1'b1;
        step();
        check("bp.accept.valid", 32'(valid_o), 32'd0);
        check("bp.accept.press", 32'(press_cnt_o), 32'd4);
        pulse_cycles = 0;
        repeat (12) step();
        a_n = '1;
        repeat (3) step();
        a_n = ~9'h010;
        repeat (15) step();
        check("bp.norepeat", 32'(pulse_cycles), 32'd0);
        a_n = '1;
        repeat (8) step();

        // Randomised traffic against the model.
        for (int t = 0; t < 300; t++) begin
            int hold;
            if ($urandom_range(0, 1) == 0) a_n = '1;
            else a_n = 9'($urandom);
            hold = int'($urandom_range(1, 12));
            for (int j = 0; j < hold; j++) begin
                ready_i = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        a_n = '1;
        ready_i = 1'b1;
        repeat (10) step();

        // Saturation of the press counter.
        for (int t = 0; t < 256; t++) begin
            a_n = ~(9'h001 << $urandom_range(0, 8));
            repeat (8) step();
            a_n = '1;
            repeat (7) step();
        end
        check("sat.press", 32'(press_cnt_o), 32'd255);

        // Asynchronous reset mid-debounce, then full latency on a held key.
        a_n = ~9'h010;
        repeat (4) step();
        check("arst.pre.busy", 32'(busy_o), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(valid_o), 32'd0);
        check("arst.code",  32'(code_o), 32'hF);
        check("arst.busy",  32'(busy_o), 32'd0);
        check("arst.press", 32'(press_cnt_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_all("arst.rel");
        wait_valid(20, k, c);
        check("arst.latency", 32'(k), 32'd7);
        check("arst.code5", 32'(c), 32'hA);
        a_n = '1;
        repeat (8) step();

        // Reset mid-present discards the pending code.
        ready_i = 1'b0;
        a_n = ~9'h004;
        wait_valid(20, k, c);
        check("prst.seen", 32'(k != 0), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("prst.valid", 32'(valid_o), 32'd0);
        a_n = '1;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_cycles = 0;
        repeat (12) step();
        check("prst.nopulse", 32'(pulse_cycles), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prio_key_encoder.md
PRIO_KEY_ENCODER -- requirements
Module: prio_key_encoder

Interface
REQ-001 The block SHALL have parameter N_IN, default 9, number of active-low request inputs, legal range 2..15.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 4, number of consecutive stable cycles required for debounce, legal range 1..255.
REQ-003 The block SHALL have parameter ACTIVE_LOW_OUT, default 1; 1 means code_o is bit-inverted, 0 means code_o is true binary.
REQ-004 The block SHALL define derived width CW = $clog2(N_IN+1), which is 4 at default.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port a_n, input, N_IN bits, asynchronous active-low request lines.
REQ-009 The block SHALL have port ready_i, input, 1 bit, consumer accepts the code.
REQ-010 The block SHALL have port valid_o, output, 1 bit, a debounced code is presented.
REQ-011 The block SHALL have port code_o, output, CW bits, registered encoded key.
REQ-012 The block SHALL have port busy_o, output, 1 bit, high when the FSM is not in IDLE.
REQ-013 The block SHALL have port press_cnt_o, output, 8 bits, count of accepted codes.
REQ-014 Elaboration SHALL fail if N_IN or DEB_CYCLES is outside its legal range.

Function
REQ-015 a_n SHALL pass through a 2-flop synchronizer, with all flops reset to 1 (inactive).
REQ-016 The combinational encoding SHALL be: enc = i+1, where i is the highest index with synchronized a_n[i]==0; enc = 0 when no line is low.
REQ-017 The FSM SHALL have states IDLE, DEBOUNCE, PRESENT and RELEASE, plus an internal counter cnt and a candidate register cand (CW bits).
REQ-018 In IDLE, on an edge with enc!=0, the FSM SHALL set cand=enc, set cnt=0 and go to DEBOUNCE; otherwise it SHALL stay in IDLE.
REQ-019 In DEBOUNCE, on an edge with enc==cand, the FSM SHALL go to PRESENT if cnt==DEB_CYCLES-1, otherwise increment cnt.
REQ-020 In DEBOUNCE, on an edge with enc!=cand and enc!=0, the FSM SHALL set cand=enc and cnt=0, and stay in DEBOUNCE.
REQ-021 In DEBOUNCE, on an edge with enc==0, the FSM SHALL go to IDLE.
REQ-022 On entry to PRESENT, the block SHALL register code_o from cand and set valid_o=1.
REQ-023 Latency: when a_n is stable from edge 1 (the first edge to sample it), valid_o SHALL rise after edge DEB_CYCLES+3, which is edge 7 at default.
REQ-024 In PRESENT, valid_o and code_o SHALL be held stable until an edge with ready_i==1, and a_n changes SHALL be ignored.
REQ-025 In PRESENT, on an edge with ready_i==1, the block SHALL clear valid_o, increment press_cnt_o (saturating at 255, no wrap) and go to RELEASE.
REQ-026 The handshake SHALL complete in one cycle when ready_i is already high on PRESENT entry, so valid_o is high for exactly one cycle.
REQ-027 In RELEASE, the FSM SHALL go to IDLE after DEB_CYCLES consecutive edges with enc==0.
REQ-028 In RELEASE, any edge with enc!=0 SHALL reset the release count, and no new code SHALL be produced while in RELEASE (no auto-repeat).
REQ-029 When valid_o==0, code_o SHALL equal the idle code (0 encoded per ACTIVE_LOW_OUT, which is 4'b1111 at default).
REQ-030 busy_o SHALL be registered-state decoded, with no combinational path from a_n or ready_i.
REQ-031 ready_i SHALL be ignored in every state except PRESENT.
REQ-032 valid_o, code_o and busy_o SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-033 When rst_n==0, the block SHALL immediately (asynchronously) force state=IDLE, cnt=0, cand=0, synchronizer=all ones, valid_o=0, code_o=idle code, busy_o=0 and press_cnt_o=0.
REQ-034 A reset asserted mid-DEBOUNCE, mid-PRESENT or mid-RELEASE SHALL discard the pending code, with no valid_o pulse after release.
REQ-035 After rst_n deasserts, a held key SHALL be processed from IDLE with the full latency of REQ-023.

Verification (N_IN=9, DEB_CYCLES=4, ACTIVE_LOW_OUT=1)
REQ-036 Scenario reset: rst_n=0 with a_n=9'h000 -> code_o=4'b1111, valid_o=0, busy_o=0, press_cnt_o=0.
REQ-037 Scenario single key: a_n[8]=0 held with ready_i=1 -> valid_o=1 for one cycle after edge 7, code_o=4'b0110, press_cnt_o=1, and no second pulse while held.
REQ-038 Scenario priority: a_n[2] and a_n[6] low together -> code_o=4'b1000 (code 7).
REQ-039 Scenario bounce: a_n[3] toggles every 2 cycles for 20 cycles then is held low -> exactly one valid_o with code_o=4'b1011.
REQ-040 Scenario backpressure: ready_i=0 for 10 cycles, with a_n switched to [1] mid-hold -> valid_o and code_o stay unchanged.
REQ-041 Scenario backpressure release: after ready_i=1 the code is accepted, and no new valid_o occurs until all keys are released for 4 cycles.
REQ-042 Scenario saturation and async reset: 256 accepted presses -> press_cnt_o=255.
REQ-043 Scenario saturation and async reset: rst_n pulsed between edges while in DEBOUNCE -> outputs take reset values before the next edge.
